// File: rtl/nn_pkg.sv
// Shared definitions for the fully-connected layer datapath.
//   DATA_W        : activation / result word width
//   BIAS_TICK_DEF : default tick on which neurons inject bias
//   ACC_LAT_DEF   : default cycles from last X to valid Z
//   seq_state_t   : layer sequencer state encoding
//   relu16        : clamp a signed word at zero
package nn_pkg;

  localparam int DATA_W        = 16;
  localparam int BIAS_TICK_DEF = 3;
  localparam int ACC_LAT_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  function automatic logic [DATA_W-1:0] relu16(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Bundle between a layer sequencer, its input/output buffers and its neurons.
//   master : sequencer side (drives timing, X broadcast, buffer addresses, Y writes)
//   slave  : environment side (Start, input buffer data, neuron results)
// Signals:
//   Start, Busy, Done          : pass control / status
//   Active, Tick, X            : broadcast to neurons
//   X_Addr, X_Data             : input buffer read port (1-cycle latency)
//   Z_In                       : packed neuron results, neuron j at [16j+15:16j]
//   Y_Addr, Y_Data, Y_We       : output buffer write port
interface layer_sequencer_if
  import nn_pkg::*;
#(
  parameter int N_IN   = 784,
  parameter int N_OUT  = 20,
  parameter int TICK_W = 10
) ();

  localparam int XA_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int YA_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic                      Start;
  logic                      Busy;
  logic                      Done;
  logic                      Active;
  logic [TICK_W-1:0]         Tick;
  logic [XA_W-1:0]           X_Addr;
  logic [DATA_W-1:0]         X_Data;
  logic [DATA_W-1:0]         X;
  logic [N_OUT*DATA_W-1:0]   Z_In;
  logic [YA_W-1:0]           Y_Addr;
  logic [DATA_W-1:0]         Y_Data;
  logic                      Y_We;

  modport master (
    input  Start, X_Data, Z_In,
    output Busy, Done, Active, Tick, X_Addr, X, Y_Addr, Y_Data, Y_We
  );

  modport slave (
    output Start, X_Data, Z_In,
    input  Busy, Done, Active, Tick, X_Addr, X, Y_Addr, Y_Data, Y_We
  );

endinterface

// File: rtl/layer_sequencer_relu_snapshot.sv
// Register bank holding one ReLU'd result per neuron.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture every neuron result through ReLU in one cycle
//   z_in     : packed neuron results, neuron j at [16j+15:16j]
//   rd_idx   : read index
//   rd_data  : bank[rd_idx], zero when rd_idx is past the last neuron
module relu_snapshot
  import nn_pkg::*;
#(
  parameter int N_OUT = 20,
  parameter int IDX_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [N_OUT*DATA_W-1:0] z_in,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_W-1:0]       rd_data
);

  logic [DATA_W-1:0] bank [N_OUT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N_OUT; j++) begin
        bank[j] <= '0;
      end
    end else if (load) begin
      for (int j = 0; j < N_OUT; j++) begin
        bank[j] <= relu16(z_in[DATA_W*j +: DATA_W]);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_idx) < N_OUT) begin
      rd_data = bank[rd_idx];
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Sequencer for one fully-connected layer: streams the input vector to all
// neurons in parallel, drives the shared Active/Tick timing, snapshots the
// neuron results through ReLU and writes them to the next layer's buffer.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : layer_sequencer_if.master (control, neuron broadcast,
//                input buffer read port, output buffer write port)
//
// state | meaning
// IDLE  | waiting for Start; Active=0, X=0
// RUN   | Tick 0..T_CAP; X streamed from the input buffer; last tick captures Z
// WRITE | one ReLU'd result per cycle into the output buffer; Active=0
// DONE  | one-cycle Done pulse, Start ignored
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int N_IN      = 784,
  parameter int N_OUT     = 20,
  parameter int BIAS_TICK = BIAS_TICK_DEF,
  parameter int ACC_LAT   = ACC_LAT_DEF,
  parameter int TICK_W    = $clog2(BIAS_TICK + N_IN + ACC_LAT + 1)
) (
  input logic               Clk,
  input logic               Reset,
  layer_sequencer_if.master bus
);

  localparam int XA_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int YA_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int T_CAP = BIAS_TICK + N_IN + ACC_LAT;

  localparam logic [TICK_W-1:0] T_CAP_T = TICK_W'(T_CAP);
  localparam logic [TICK_W-1:0] XA_LO   = TICK_W'(BIAS_TICK);
  localparam logic [TICK_W-1:0] XA_HI   = TICK_W'(BIAS_TICK + N_IN - 1);
  localparam logic [TICK_W-1:0] XV_LO   = TICK_W'(BIAS_TICK + 1);
  localparam logic [TICK_W-1:0] XV_HI   = TICK_W'(BIAS_TICK + N_IN);
  localparam logic [YA_W-1:0]   Y_LAST  = YA_W'(N_OUT - 1);

  seq_state_t          state_q;
  logic                busy_q;
  logic                done_q;
  logic                active_q;
  logic                x_en_q;
  logic                y_we_q;
  logic [TICK_W-1:0]   tick_q;
  logic [TICK_W-1:0]   tick_nx;
  logic [XA_W-1:0]     x_addr_q;
  logic [YA_W-1:0]     y_addr_q;
  logic [YA_W-1:0]     snap_idx;
  logic [DATA_W-1:0]   y_data_q;
  logic [DATA_W-1:0]   snap_rd;
  logic                cap_now;

  assign tick_nx  = tick_q + TICK_W'(1);
  assign cap_now  = (state_q == RUN) && (tick_q == T_CAP_T);
  // Y_Data is registered, so the bank is read one entry ahead of Y_Addr.
  assign snap_idx = y_addr_q + YA_W'(1);

  relu_snapshot #(
    .N_OUT (N_OUT),
    .IDX_W (YA_W)
  ) u_snap (
    .clk     (Clk),
    .rst     (Reset),
    .load    (cap_now),
    .z_in    (bus.Z_In),
    .rd_idx  (snap_idx),
    .rd_data (snap_rd)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
      x_en_q   <= 1'b0;
      tick_q   <= '0;
      x_addr_q <= '0;
      y_addr_q <= '0;
      y_data_q <= '0;
      y_we_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.Start) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            active_q <= 1'b1;
            tick_q   <= '0;
            x_en_q   <= 1'b0;
            if (BIAS_TICK == 0) begin
              x_addr_q <= '0;
            end
          end
        end
        RUN: begin
          if (tick_q == T_CAP_T) begin
            // Entry 0 bypasses the bank, which only loads on this same edge.
            state_q  <= WRITE;
            active_q <= 1'b0;
            tick_q   <= '0;
            x_en_q   <= 1'b0;
            y_we_q   <= 1'b1;
            y_addr_q <= '0;
            y_data_q <= relu16(bus.Z_In[DATA_W-1:0]);
          end else begin
            tick_q <= tick_nx;
            if (tick_nx >= XA_LO && tick_nx <= XA_HI) begin
              x_addr_q <= XA_W'(tick_nx - XA_LO);
            end
            x_en_q <= (tick_nx >= XV_LO) && (tick_nx <= XV_HI);
          end
        end
        WRITE: begin
          if (y_addr_q == Y_LAST) begin
            state_q <= DONE;
            y_we_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            y_addr_q <= snap_idx;
            y_data_q <= snap_rd;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The input buffer's output register is the pipeline stage for X; the
  // registered window flag zeroes it outside the data ticks (bias tick included).
  assign bus.X      = x_en_q ? bus.X_Data : '0;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.Active = active_q;
  assign bus.Tick   = tick_q;
  assign bus.X_Addr = x_addr_q;
  assign bus.Y_Addr = y_addr_q;
  assign bus.Y_Data = y_data_q;
  assign bus.Y_We   = y_we_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench: a small layer (N_IN=4, N_OUT=3) for cycle-exact checks and
// a default-size layer (784 -> 20) for full-pass timing.
module tb_layer_sequencer;

  logic clk = 1'b0;
  logic rst_s;
  logic rst_d;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] mem_s [4];
  logic [15:0] mem_d [784];

  always #5 clk = ~clk;

  layer_sequencer_if #(.N_IN(4), .N_OUT(3), .TICK_W(4)) bus_s ();
  layer_sequencer_if #(.N_IN(784), .N_OUT(20), .TICK_W(10)) bus_d ();

  layer_sequencer #(
    .N_IN(4), .N_OUT(3), .BIAS_TICK(3), .ACC_LAT(2), .TICK_W(4)
  ) dut_s (
    .Clk   (clk),
    .Reset (rst_s),
    .bus   (bus_s)
  );

  layer_sequencer #(
    .N_IN(784), .N_OUT(20), .BIAS_TICK(3), .ACC_LAT(2), .TICK_W(10)
  ) dut_d (
    .Clk   (clk),
    .Reset (rst_d),
    .bus   (bus_d)
  );

  // Input buffers with 1-cycle read latency.
  always @(posedge clk) begin
    bus_s.X_Data <= mem_s[bus_s.X_Addr];
    if (int'(bus_d.X_Addr) < 784) bus_d.X_Data <= mem_d[bus_d.X_Addr];
    else bus_d.X_Data <= 16'h0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_s = 1'b1;
    rst_d = 1'b1;
    bus_s.Start = 1'b0;
    bus_d.Start = 1'b0;
    bus_s.Z_In = '0;
    bus_d.Z_In = '0;
    step();
    step();
    rst_s = 1'b0;
    rst_d = 1'b0;
    step();
    n_checks++; if (bus_s.Busy !== 1'b0) begin n_fail++; $display("FAIL reset Busy got %b want 0", bus_s.Busy); end
    n_checks++; if (bus_s.Done !== 1'b0) begin n_fail++; $display("FAIL reset Done got %b want 0", bus_s.Done); end
    n_checks++; if (bus_s.Active !== 1'b0) begin n_fail++; $display("FAIL reset Active got %b want 0", bus_s.Active); end
    n_checks++; if (bus_s.Tick !== 4'd0) begin n_fail++; $display("FAIL reset Tick got %0d want 0", bus_s.Tick); end
    n_checks++; if (bus_s.X_Addr !== 2'd0) begin n_fail++; $display("FAIL reset X_Addr got %0d want 0", bus_s.X_Addr); end
    n_checks++; if (bus_s.X !== 16'd0) begin n_fail++; $display("FAIL reset X got %0d want 0", bus_s.X); end
    n_checks++; if (bus_s.Y_We !== 1'b0) begin n_fail++; $display("FAIL reset Y_We got %b want 0", bus_s.Y_We); end
    n_checks++; if (bus_s.Y_Addr !== 2'd0) begin n_fail++; $display("FAIL reset Y_Addr got %0d want 0", bus_s.Y_Addr); end
    n_checks++; if (bus_s.Y_Data !== 16'd0) begin n_fail++; $display("FAIL reset Y_Data got %0d want 0", bus_s.Y_Data); end
    n_checks++; if (bus_d.Busy !== 1'b0 || bus_d.Active !== 1'b0 || bus_d.Tick !== 10'd0) begin
      n_fail++; $display("FAIL reset default Busy/Active/Tick got %b/%b/%0d want 0/0/0", bus_d.Busy, bus_d.Active, bus_d.Tick);
    end
  endtask

  task automatic test_x_stream();
    int exp_x [10] = '{0, 0, 0, 0, 10, 20, 30, 40, 0, 0};
    int exp_a;
    bus_s.Start = 1'b1;
    step();
    bus_s.Start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      n_checks++; if (bus_s.Tick !== 4'(k)) begin n_fail++; $display("FAIL x_stream Tick got %0d want %0d", bus_s.Tick, k); end
      n_checks++; if (bus_s.X !== 16'(exp_x[k])) begin n_fail++; $display("FAIL x_stream tick %0d X got %0d want %0d", k, bus_s.X, exp_x[k]); end
      n_checks++; if (bus_s.Active !== 1'b1 || bus_s.Busy !== 1'b1) begin
        n_fail++; $display("FAIL x_stream tick %0d Active/Busy got %b/%b want 1/1", k, bus_s.Active, bus_s.Busy);
      end
      if (k >= 3) begin
        exp_a = (k <= 6) ? k - 3 : 3;
        n_checks++; if (bus_s.X_Addr !== 2'(exp_a)) begin n_fail++; $display("FAIL x_stream tick %0d X_Addr got %0d want %0d", k, bus_s.X_Addr, exp_a); end
      end
      step();
    end
    for (int k = 0; k < 4; k++) step();
  endtask

  task automatic test_relu_write(input logic [47:0] z, input logic [15:0] e0,
                                 input logic [15:0] e1, input logic [15:0] e2);
    logic [15:0] e;
    bus_s.Z_In = {3{16'h1111}};
    bus_s.Start = 1'b1;
    step();
    bus_s.Start = 1'b0;
    for (int c = 1; c < 10; c++) step();
    n_checks++; if (bus_s.Tick !== 4'd9) begin n_fail++; $display("FAIL relu_write capture Tick got %0d want 9", bus_s.Tick); end
    bus_s.Z_In = z;
    step();
    bus_s.Z_In = {3{16'h2222}};
    for (int j = 0; j < 3; j++) begin
      e = (j == 0) ? e0 : ((j == 1) ? e1 : e2);
      n_checks++; if (bus_s.Y_We !== 1'b1 || bus_s.Y_Addr !== 2'(j) || bus_s.Y_Data !== e) begin
        n_fail++; $display("FAIL relu_write write %0d got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h", j, bus_s.Y_We, bus_s.Y_Addr, bus_s.Y_Data, j, e);
      end
      n_checks++; if (bus_s.Active !== 1'b0 || bus_s.Tick !== 4'd0 || bus_s.Busy !== 1'b1) begin
        n_fail++; $display("FAIL relu_write write %0d Active/Tick/Busy got %b/%0d/%b want 0/0/1", j, bus_s.Active, bus_s.Tick, bus_s.Busy);
      end
      step();
    end
    n_checks++; if (bus_s.Done !== 1'b1 || bus_s.Busy !== 1'b0 || bus_s.Y_We !== 1'b0) begin
      n_fail++; $display("FAIL relu_write done cycle Done/Busy/Y_We got %b/%b/%b want 1/0/0", bus_s.Done, bus_s.Busy, bus_s.Y_We);
    end
    step();
    n_checks++; if (bus_s.Done !== 1'b0) begin n_fail++; $display("FAIL relu_write Done pulse width got %b want 0", bus_s.Done); end
  endtask

  task automatic test_default_pass();
    int cyc = 1;
    int done_cyc = -1;
    int max_tick = 0;
    int tick790 = -1;
    int we_cnt = 0;
    int data_sum = 0;
    int addr_sum = 0;
    for (int j = 0; j < 20; j++) bus_d.Z_In[16*j +: 16] = (j == 5) ? 16'hFFF0 : 16'(j * 7);
    bus_d.Start = 1'b1;
    step();
    bus_d.Start = 1'b0;
    while (cyc < 1000 && done_cyc < 0) begin
      if (bus_d.Done === 1'b1) begin
        done_cyc = cyc;
      end else begin
        if (int'(bus_d.Tick) > max_tick) max_tick = int'(bus_d.Tick);
        if (cyc == 790) tick790 = int'(bus_d.Tick);
        if (bus_d.Y_We === 1'b1) begin
          we_cnt++;
          data_sum += int'(bus_d.Y_Data);
          addr_sum += int'(bus_d.Y_Addr);
        end
        step();
        cyc++;
      end
    end
    n_checks++; if (done_cyc != 811) begin n_fail++; $display("FAIL default Done cycle got %0d want 811", done_cyc); end
    n_checks++; if (tick790 != 789) begin n_fail++; $display("FAIL default Tick at c+790 got %0d want 789", tick790); end
    n_checks++; if (max_tick != 789) begin n_fail++; $display("FAIL default max Tick got %0d want 789", max_tick); end
    n_checks++; if (we_cnt != 20) begin n_fail++; $display("FAIL default Y_We pulses got %0d want 20", we_cnt); end
    n_checks++; if (data_sum != 1295) begin n_fail++; $display("FAIL default Y_Data sum got %0d want 1295", data_sum); end
    n_checks++; if (addr_sum != 190) begin n_fail++; $display("FAIL default Y_Addr sum got %0d want 190", addr_sum); end
    step();
  endtask

  task automatic test_start_held();
    int done_cnt = 0;
    int done1 = -1;
    int done2 = -1;
    int we_cnt = 0;
    bus_s.Start = 1'b1;
    step();
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (bus_s.Done === 1'b1) begin
        done_cnt++;
        if (done1 < 0) done1 = cyc;
        else done2 = cyc;
      end
      if (bus_s.Y_We === 1'b1) we_cnt++;
      if (cyc == 15) begin
        n_checks++; if (bus_s.Busy !== 1'b0 || bus_s.Active !== 1'b0) begin
          n_fail++; $display("FAIL start_held idle gap Busy/Active got %b/%b want 0/0", bus_s.Busy, bus_s.Active);
        end
      end
      if (cyc == 16) begin
        n_checks++; if (bus_s.Busy !== 1'b1 || bus_s.Active !== 1'b1 || bus_s.Tick !== 4'd0) begin
          n_fail++; $display("FAIL start_held second pass Busy/Active/Tick got %b/%b/%0d want 1/1/0", bus_s.Busy, bus_s.Active, bus_s.Tick);
        end
      end
      if (cyc == 30) bus_s.Start = 1'b0;
      step();
    end
    n_checks++; if (done_cnt != 2) begin n_fail++; $display("FAIL start_held Done count got %0d want 2", done_cnt); end
    n_checks++; if (done1 != 14 || done2 != 29) begin n_fail++; $display("FAIL start_held Done cycles got %0d,%0d want 14,29", done1, done2); end
    n_checks++; if (we_cnt != 6) begin n_fail++; $display("FAIL start_held Y_We count got %0d want 6", we_cnt); end
    step();
    step();
    n_checks++; if (bus_s.Busy !== 1'b0) begin n_fail++; $display("FAIL start_held third pass Busy got %b want 0", bus_s.Busy); end
  endtask

  task automatic test_reset_mid();
    int we_cnt = 0;
    int done_cnt = 0;
    bus_s.Start = 1'b1;
    step();
    bus_s.Start = 1'b0;
    step();
    step();
    n_checks++; if (bus_s.Tick !== 4'd2) begin n_fail++; $display("FAIL reset_mid pre Tick got %0d want 2", bus_s.Tick); end
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    n_checks++; if (bus_s.Active !== 1'b0 || bus_s.Busy !== 1'b0 || bus_s.Tick !== 4'd0) begin
      n_fail++; $display("FAIL reset_mid Active/Busy/Tick got %b/%b/%0d want 0/0/0", bus_s.Active, bus_s.Busy, bus_s.Tick);
    end
    for (int c = 0; c < 20; c++) begin
      if (bus_s.Y_We === 1'b1) we_cnt++;
      if (bus_s.Done === 1'b1) done_cnt++;
      step();
    end
    n_checks++; if (we_cnt != 0 || done_cnt != 0) begin
      n_fail++; $display("FAIL reset_mid after reset Y_We/Done counts got %0d/%0d want 0/0", we_cnt, done_cnt);
    end
    n_checks++; if (bus_s.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid idle Busy got %b want 0", bus_s.Busy); end
  endtask

  initial begin
    mem_s[0] = 16'd10;
    mem_s[1] = 16'd20;
    mem_s[2] = 16'd30;
    mem_s[3] = 16'd40;
    for (int i = 0; i < 784; i++) mem_d[i] = 16'(i + 1);
    test_reset();
    test_x_stream();
    test_relu_write({16'd300, 16'd0, 16'hFFFB}, 16'd0, 16'd0, 16'd300);
    test_relu_write({16'hFFFF, 16'h7FFF, 16'h8000}, 16'h0000, 16'h7FFF, 16'h0000);
    test_default_pass();
    test_start_held();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Drives one fully-connected layer of the MNIST network. Streams the input activation vector from the layer's input buffer to every neuron of the layer in parallel, and generates the shared `Active`/`Tick` timing that the neurons use to select weights and inject bias. Captures all neuron results at the end of the pass, applies ReLU, and writes them sequentially into the next layer's input buffer. One instance per layer: 784→20, 20→20, 20→10.

## Interface
Parameters:
- `N_IN`, 784: input vector length.
- `N_OUT`, 20: neurons driven in parallel.
- `BIAS_TICK`, 3: tick on which the neurons inject bias; `X` must be 0 on this tick.
- `ACC_LAT`, 2: cycles from the last `X` to a valid `Z`.
- `TICK_W`, `$clog2(BIAS_TICK+N_IN+ACC_LAT+1)`: width of `Tick`, 10 at defaults.

Ports:
- `Clk` in 1: clock. One clock domain; all logic is on its rising edge.
- `Reset` in 1: synchronous, active-high.
- `Start` in 1: begin a pass. Sampled only in IDLE.
- `Busy` out 1: high in RUN, CAPTURE and WRITE.
- `Done` out 1: one-cycle pulse at the end of a pass.
- `Active` out 1: to neurons; low clears their accumulators.
- `Tick` out TICK_W: to neurons; pass cycle index.
- `X_Addr` out `$clog2(N_IN)`: input buffer read address. The buffer has 1-cycle read latency.
- `X_Data` in 16: input buffer read data.
- `X` out 16: broadcast to all neurons.
- `Z_In` in `N_OUT*16`: neuron results, packed; neuron j occupies `[16j+15:16j]`. Signed.
- `Y_Addr` out `$clog2(N_OUT)`: output buffer write address.
- `Y_Data` out 16: ReLU result.
- `Y_We` out 1: output buffer write enable.

## Operation
- Every output resets to 0. The state resets to IDLE.
- **IDLE:**
  - `Active`=0, `X`=0.
  - `Start`=1 moves to RUN with `Tick`=0.
- **RUN:**
  - `Active`=1. `Tick` increments every cycle, from 0 to `T_CAP = BIAS_TICK+N_IN+ACC_LAT`.
  - `X_Addr = Tick-BIAS_TICK` for `Tick` in `[BIAS_TICK, BIAS_TICK+N_IN-1]`. Outside that range `X_Addr` holds its last value.
  - On tick t, `X = X_Data` (that is, `mem[t-BIAS_TICK-1]`) for t in `[BIAS_TICK+1, BIAS_TICK+N_IN]`. On every other tick `X`=0, which includes the bias tick.
  - At `Tick==T_CAP`, register all `N_OUT` values `Z_In[j]` into a snapshot with ReLU applied: a negative (bit 15 set) value becomes 0, otherwise it passes unchanged. Then go to WRITE.
- **WRITE:**
  - `Active`=0 and `Tick`=0, which clears the neuron accumulators.
  - One write per cycle: `Y_We`=1, `Y_Addr`=j, `Y_Data`=snapshot[j], for j = 0..N_OUT-1.
  - After j = N_OUT-1, go to DONE.
- **DONE:** `Done`=1 for one cycle, `Busy`=0, then IDLE.
- Boundary conditions:
  - `Start` in any state other than IDLE is ignored, including in DONE.
  - `Reset` mid-pass returns to IDLE on the next edge. `Active`, `Y_We` and `Done` drop immediately, and no further writes occur.
  - `Z_In` is not sampled outside the `T_CAP` cycle.

## Timing
- `Start` sampled high in IDLE at cycle c.
- c+1: `Tick`=0, `Active`=1, `Busy`=1.
- `Tick` = k at cycle c+1+k.
- Capture at cycle c+1+T_CAP.
- Writes in cycles c+2+T_CAP through c+1+T_CAP+N_OUT.
- `Done` at c+2+T_CAP+N_OUT. At defaults: T_CAP = 789, `Done` at c+811.
- Back-to-back passes: the earliest new `Start` is sampled one cycle after `Done`.
- `X`, `Active`, `Tick`, `Y_*` and `Done` are all registered outputs.

## Structure
- Shared package `nn_pkg`:
  - `DATA_W`=16.
  - `BIAS_TICK`, `ACC_LAT` defaults.
  - `seq_state_t` enum {IDLE, RUN, WRITE, DONE}.
  - `relu16` function.
- CAPTURE is the final RUN cycle, not a separate state.
- One sub-module: `relu_snapshot`. It holds an `N_OUT`×16 register bank, loads all entries through ReLU on `load`, and provides a read mux on index j.

## Test plan
- `N_IN`=4, `N_OUT`=3. Buffer holds {10, 20, 30, 40}, `Start` at c -> `X` over ticks 0..9 = 0,0,0,0,10,20,30,40,0,0. `X_Addr` is 0..3 on ticks 3..6.
- Same configuration, `Z_In` = {-5, 0, 300} at `T_CAP` -> writes (0,0), (1,0), (2,300) in consecutive cycles. `Done` at c+14.
- Defaults -> `Tick` reaches 789 (no wrap), `Done` at c+811, exactly 20 `Y_We` pulses.
- `Start` held high for a whole pass -> a second pass begins only after IDLE. Exactly 2×`N_OUT` writes over two passes.
- `Reset` at `Tick`=2 -> next cycle `Active`=0, `Busy`=0, no `Y_We`, no `Done`.
- `Z_In` = 0x8000 and 0x7FFF -> outputs 0 and 0x7FFF.
